hazard_fwd_ctrl: RTL and testbench
==================================

HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, register-index width.
REQ-002 The block SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 The block SHALL have parameter FWD_EN, default 1; 1 = forwarding mode, 0 = stall-only mode.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port id_valid  input  1  ID stage holds a real instruction.
REQ-007 The block SHALL have ports id_rs, id_rt  input  ADDR_W each  ID source registers.
REQ-008 The block SHALL have ports id_use_rs, id_use_rt  input  1 each  the matching source is actually read.
REQ-009 The block SHALL have ports id_dst  input  ADDR_W, id_reg_write  input  1, id_mem_read  input  1  ID instruction's write target, write enable and load flag.
REQ-010 The block SHALL have port ex_branch_taken  input  1  branch in EX resolved taken this cycle.
REQ-011 The block SHALL have port clr_cnt  input  1  synchronous clear of stall_cnt.
REQ-012 The block SHALL have port stall  output  1  hold PC and IF/ID, insert bubble into ID/EX (combinational).
REQ-013 The block SHALL have ports flush_ifid, flush_idex  output  1 each  squash these pipeline registers (combinational).
REQ-014 The block SHALL have ports fwd_a, fwd_b  output  2 each, registered  ALU operand select for the instruction now in EX: 00 register file, 01 EX/MEM, 10 MEM/WB; 11 never driven.
REQ-015 The block SHALL have port stall_cnt  output  CNT_W  count of stall cycles.

Function
REQ-016 The block SHALL keep a 3-entry scoreboard (EX, MEM, WB), each entry holding {valid, dst, reg_write, mem_read}.
REQ-017 Each cycle without flush or stall, the block SHALL shift ID->EX, EX->MEM and MEM->WB; the ID entry is valid only if id_valid=1.
REQ-018 On stall, EX SHALL load a bubble (valid=0) while MEM<=EX and WB<=MEM still shift.
REQ-019 On flush, EX SHALL load a bubble, MEM<=EX and WB<=MEM shift.
REQ-020 A source SHALL match an entry only if the source is used, the source is nonzero, and the entry has valid=1, reg_write=1 and dst equal to the source; register 0 never matches.
REQ-021 With FWD_EN=1, stall SHALL be 1 iff id_valid=1 and a source matches EX with mem_read=1 (load-use); this is a 1-cycle stall.
REQ-022 With FWD_EN=0, stall SHALL be 1 iff id_valid=1 and a source matches EX or MEM; a WB match does not stall, because the register file writes before it is read in the same cycle.
REQ-023 ex_branch_taken=1 SHALL assert flush_ifid=1 and flush_idex=1 in the same cycle and force stall=0.
REQ-024 With FWD_EN=1, when the ID instruction advances (no stall, no flush), fwd_a/fwd_b SHALL be registered from the id_rs/id_rt matches: an EX-entry match gives 01, else a MEM-entry match gives 10, else 00. EX takes priority because it is the youngest producer.
REQ-025 On a stall or flush cycle, fwd_a and fwd_b SHALL register 00. With FWD_EN=0 they SHALL always be 00.
REQ-026 stall_cnt SHALL increment by 1 in each cycle where stall=1 is sampled, and SHALL saturate at all-ones.
REQ-027 clr_cnt SHALL clear stall_cnt to 0 and SHALL win over a simultaneous increment.
REQ-028 All outputs SHALL be combinational from state and inputs, or registered; there SHALL be no combinational loop through stall.

Reset
REQ-029 While rst=1, all scoreboard entries SHALL be invalid, fwd_a=fwd_b=00 and stall_cnt=0, asynchronously.
REQ-030 Because the scoreboard is empty during reset, stall, flush_ifid and flush_idex SHALL be 0 during reset unless ex_branch_taken=1.
REQ-031 A reset asserted mid-stall SHALL drop the stall with no residual bubble after reset release.

Verification
REQ-032 Stimulus: FWD_EN=1; ID add r3 (writes r3), then ID sub using rs=r3 -> no stall; fwd_a=01 while sub is in EX.
REQ-033 Stimulus: FWD_EN=1; lw r5, then next instruction with rt=r5 -> stall=1 for exactly 1 cycle, stall_cnt=1; then fwd_b=10 while the consumer is in EX.
REQ-034 Stimulus: same producer r4 in both EX and MEM (two writes to r4), consumer reads r4 -> fwd_a=01 (youngest producer wins).
REQ-035 Stimulus: FWD_EN=0; add r7, then consumer reading r7 -> stall=1 for 2 cycles, stall_cnt=2, fwd_a=00 throughout.
REQ-036 Stimulus: load-use hazard and ex_branch_taken=1 in the same cycle -> stall=0, flush_ifid=flush_idex=1, stall_cnt unchanged; a consumer reading r0 after a write to r0 -> no stall, fwd=00.
REQ-037 Stimulus: CNT_W=2 with 5 stall cycles -> stall_cnt=3 (saturated); then clr_cnt and stall asserted together -> stall_cnt=0; rst asserted mid-stall -> outputs return to 0 immediately.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and forwarding control for a 5-stage in-order pipeline.
// Tracks the producers in EX/MEM/WB and decides stall, flush and ALU operand bypass.
module hazard_fwd_ctrl #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned FWD_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [ADDR_W-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  input  logic              clr_cnt,
  output logic              stall,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dst;
    logic              reg_write;
    logic              mem_read;
  } entry_t;

  localparam logic [1:0] SelRf    = 2'b00;
  localparam logic [1:0] SelExMem = 2'b01;
  localparam logic [1:0] SelMemWb = 2'b10;

  entry_t           ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic a_ex, b_ex, a_mem, b_mem;
  logic hazard;

  // Register 0 is hardwired to zero, so it never creates a dependency.
  function automatic logic src_hit(input logic use_src, input logic [ADDR_W-1:0] src,
                                   input entry_t e);
    return use_src && (src != '0) && e.valid && e.reg_write && (e.dst == src);
  endfunction

  always_comb begin
    a_ex  = src_hit(id_use_rs, id_rs, ex_q);
    b_ex  = src_hit(id_use_rt, id_rt, ex_q);
    a_mem = src_hit(id_use_rs, id_rs, mem_q);
    b_mem = src_hit(id_use_rt, id_rt, mem_q);

    if (FWD_EN != 0) begin
      hazard = id_valid && (a_ex || b_ex) && ex_q.mem_read;
    end else begin
      // WB writes the register file before ID reads it, so only EX/MEM matter.
      hazard = id_valid && (a_ex || b_ex || a_mem || b_mem);
    end

    stall      = hazard && !ex_branch_taken;
    flush_ifid = ex_branch_taken;
    flush_idex = ex_branch_taken;
  end

  always_comb begin
    ex_d           = '0;
    mem_d          = ex_q;
    wb_d           = mem_q;
    fwd_a_d        = SelRf;
    fwd_b_d        = SelRf;
    cnt_d          = cnt_q;

    if (!stall && !ex_branch_taken) begin
      ex_d.valid     = id_valid;
      ex_d.dst       = id_dst;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      if ((FWD_EN != 0) && id_valid) begin
        fwd_a_d = a_ex ? SelExMem : (a_mem ? SelMemWb : SelRf);
        fwd_b_d = b_ex ? SelExMem : (b_mem ? SelMemWb : SelRf);
      end
    end

    if (clr_cnt) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= SelRf;
      fwd_b_q <= SelRf;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  // The WB entry completes the scoreboard but never causes a hazard.
  logic unused_wb;
  assign unused_wb = ^wb_q;

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl: three configurations share one stimulus stream;
// each expected record names the instance it applies to and is checked on the falling edge.
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       ex_branch_taken, clr_cnt;

  logic        st0, fi0, fe0, st1, fi1, fe1, st2, fi2, fe2;
  logic [1:0]  fa0, fb0, fa1, fb1, fa2, fb2;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.ADDR_W(5), .CNT_W(16), .FWD_EN(1)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .clr_cnt(clr_cnt), .stall(st0),
    .flush_ifid(fi0), .flush_idex(fe0), .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(cnt0)
  );

  hazard_fwd_ctrl #(.ADDR_W(5), .CNT_W(16), .FWD_EN(0)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .clr_cnt(clr_cnt), .stall(st1),
    .flush_ifid(fi1), .flush_idex(fe1), .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(cnt1)
  );

  hazard_fwd_ctrl #(.ADDR_W(5), .CNT_W(2), .FWD_EN(1)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .clr_cnt(clr_cnt), .stall(st2),
    .flush_ifid(fi2), .flush_idex(fe2), .fwd_a(fa2), .fwd_b(fb2), .stall_cnt(cnt2)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [22:0] val;  // {stall, flush_ifid, flush_idex, fwd_a, fwd_b, stall_cnt}
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [22:0] act;
  int n_tests = 0;
  int n_fail  = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      case (mon_e.sel)
        0:       act = {st0, fi0, fe0, fa0, fb0, cnt0};
        1:       act = {st1, fi1, fe1, fa1, fb1, cnt1};
        default: act = {st2, fi2, fe2, fa2, fb2, 14'd0, cnt2};
      endcase
      n_tests++;
      if (act !== mon_e.val) begin
        n_fail++;
        $display("FAIL %s: got st=%b fl=%b%b fa=%b fb=%b cnt=%0d, want st=%b fl=%b%b fa=%b fb=%b cnt=%0d",
                 mon_e.name, act[22], act[21], act[20], act[19:18], act[17:16], act[15:0],
                 mon_e.val[22], mon_e.val[21], mon_e.val[20], mon_e.val[19:18],
                 mon_e.val[17:16], mon_e.val[15:0]);
      end
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_dst = 0; id_reg_write = 0; id_mem_read = 0; ex_branch_taken = 0; clr_cnt = 0;
  endtask

  task automatic ins(input logic [4:0] dst, input logic rw, input logic mr,
                     input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                     input logic urt);
    id_valid = 1; id_dst = dst; id_reg_write = rw; id_mem_read = mr;
    id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    ex_branch_taken = 0; clr_cnt = 0;
  endtask

  task automatic chk(input string name, input int sel, input logic st, input logic fl,
                     input logic [1:0] fa, input logic [1:0] fb, input logic [15:0] cnt);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = {st, fl, fl, fa, fb, cnt};
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int sel);
    go(); rst = 1; nop(); chk("reset_state", sel, 0, 0, 2'b00, 2'b00, 16'd0);
    go(); rst = 0;
  endtask

  // Load r5 that also reads r5: alternates stall / advance when held in ID.
  task automatic lw_chain();
    ins(5'd5, 1, 1, 5'd5, 1, 5'd0, 0);
  endtask

  logic [15:0] sat_cnt[10] = '{0, 1, 1, 2, 2, 3, 3, 3, 3, 3};
  logic [1:0]  sat_fa[10]  = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00,
                               2'b10, 2'b00};

  initial begin
    nop();
    #12;

    // ALU producer followed by consumer: bypass from EX/MEM, no stall.
    do_reset(0);
    go(); ins(5'd3, 1, 0, 5'd0, 0, 5'd0, 0); chk("alu_prod", 0, 0, 0, 2'b00, 2'b00, 0);
    go(); ins(5'd6, 1, 0, 5'd3, 1, 5'd2, 1); chk("alu_cons_id", 0, 0, 0, 2'b00, 2'b00, 0);
    go(); nop();                             chk("alu_cons_ex", 0, 0, 0, 2'b01, 2'b00, 0);

    // Load-use: one stall, then MEM/WB bypass on rt.
    do_reset(0);
    go(); ins(5'd5, 1, 1, 5'd0, 0, 5'd0, 0); chk("lw_prod", 0, 0, 0, 2'b00, 2'b00, 0);
    go(); ins(5'd8, 1, 0, 5'd1, 1, 5'd5, 1); chk("lu_stall", 0, 1, 0, 2'b00, 2'b00, 0);
    go(); ins(5'd8, 1, 0, 5'd1, 1, 5'd5, 1); chk("lu_release", 0, 0, 0, 2'b00, 2'b00, 1);
    go(); nop();                             chk("lu_fwd_b", 0, 0, 0, 2'b00, 2'b10, 1);

    // Two writers of r4: the younger one in EX wins.
    do_reset(0);
    go(); ins(5'd4, 1, 0, 5'd0, 0, 5'd0, 0); chk("r4_w1", 0, 0, 0, 2'b00, 2'b00, 0);
    go(); ins(5'd4, 1, 0, 5'd0, 0, 5'd0, 0); chk("r4_w2", 0, 0, 0, 2'b00, 2'b00, 0);
    go(); ins(5'd9, 1, 0, 5'd4, 1, 5'd0, 0); chk("r4_cons_id", 0, 0, 0, 2'b00, 2'b00, 0);
    go(); nop();                             chk("r4_youngest", 0, 0, 0, 2'b01, 2'b00, 0);

    // Stall-only mode: dependency on EX and then MEM costs two cycles.
    do_reset(1);
    go(); ins(5'd7, 1, 0, 5'd0, 0, 5'd0, 0); chk("nf_prod", 1, 0, 0, 2'b00, 2'b00, 0);
    go(); ins(5'd9, 1, 0, 5'd7, 1, 5'd0, 0); chk("nf_stall_ex", 1, 1, 0, 2'b00, 2'b00, 0);
    go(); ins(5'd9, 1, 0, 5'd7, 1, 5'd0, 0); chk("nf_stall_mem", 1, 1, 0, 2'b00, 2'b00, 1);
    go(); ins(5'd9, 1, 0, 5'd7, 1, 5'd0, 0); chk("nf_wb_ok", 1, 0, 0, 2'b00, 2'b00, 2);
    go(); nop();                             chk("nf_no_fwd", 1, 0, 0, 2'b00, 2'b00, 2);

    // Branch flush overrides load-use stall; r0 never creates a hazard.
    do_reset(0);
    go(); ins(5'd5, 1, 1, 5'd0, 0, 5'd0, 0); chk("br_lw", 0, 0, 0, 2'b00, 2'b00, 0);
    go(); ins(5'd8, 1, 0, 5'd0, 0, 5'd5, 1); ex_branch_taken = 1;
    chk("br_flush", 0, 0, 1, 2'b00, 2'b00, 0);
    go(); nop();                             chk("br_after", 0, 0, 0, 2'b00, 2'b00, 0);
    go(); ins(5'd0, 1, 1, 5'd0, 0, 5'd0, 0); chk("r0_lw", 0, 0, 0, 2'b00, 2'b00, 0);
    go(); ins(5'd1, 1, 0, 5'd0, 1, 5'd0, 1); chk("r0_cons", 0, 0, 0, 2'b00, 2'b00, 0);
    go(); nop();                             chk("r0_fwd", 0, 0, 0, 2'b00, 2'b00, 0);

    // 2-bit counter saturation, clear-vs-increment priority, reset mid-stall.
    do_reset(2);
    go(); ins(5'd5, 1, 1, 5'd0, 0, 5'd0, 0); chk("sat_lw", 2, 0, 0, 2'b00, 2'b00, 0);
    for (int i = 0; i < 10; i++) begin
      go(); lw_chain();
      chk($sformatf("sat_step%0d", i), 2, ((i % 2) == 0), 0, sat_fa[i], 2'b00, sat_cnt[i]);
    end
    go(); lw_chain(); clr_cnt = 1;           chk("clr_stall", 2, 1, 0, 2'b10, 2'b00, 3);
    go(); nop();                             chk("clr_wins", 2, 0, 0, 2'b00, 2'b00, 0);
    go(); ins(5'd5, 1, 1, 5'd0, 0, 5'd0, 0); chk("rst_lw", 2, 0, 0, 2'b00, 2'b00, 0);
    go(); lw_chain();                        chk("rst_pre_stall", 2, 1, 0, 2'b00, 2'b00, 0);
    go(); rst = 1; lw_chain();               chk("rst_async", 2, 0, 0, 2'b00, 2'b00, 0);
    go(); rst = 0; lw_chain();               chk("rst_no_bubble", 2, 0, 0, 2'b00, 2'b00, 0);
    go(); nop();                             chk("rst_after", 2, 0, 0, 2'b00, 2'b00, 0);

    go(); go();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked records, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
